mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mips_pkg.sv | 20 ++
 rtl/arb_starve_ctr.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and width defaults for the memory-port arbiter slice.
package mips_pkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA          = 32;

  // Arbiter sequencing: IDLE and RESP both arbitrate, WAIT blocks the port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  // Identity of the requester that owns the outstanding read.
  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive arbitrations the fetch port has lost to
// load/store. starved_o tells the arbiter to let fetch win the next one.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic ls_gnt_i,
  output logic starved_o
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  // Next count: clear when fetch is idle or served, bump when it loses.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (!if_req_i || if_gnt_i) begin
      cnt_d = '0;
    end else if (ls_gnt_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starved_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, load/store) for one memory port.
// One transaction outstanding at most; load/store has priority unless fetch
// has been starved STARVE_MAX arbitrations in a row.
// Optional: define ARB_STATS_EN to add 32-bit grant counters if_acc_cnt and
// ls_acc_cnt.
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = ADDRESS_WIDTH,
  parameter int DATA_W     = DATA,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_o
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       if_acc_cnt,
  output logic [31:0]       ls_acc_cnt
`endif
);

  // Index of the last WAIT cycle, where mem_rdata is valid.
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  arb_state_e        state_q;
  req_id_e           owner_q;
  logic [2:0]        lat_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  logic starved;
  logic arb_en;
  logic pick_if;
  logic read_gnt;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .if_req_i  (if_req),
    .if_gnt_i  (if_gnt),
    .ls_gnt_i  (ls_gnt),
    .starved_o (starved)
  );

  // Arbitration happens in IDLE and RESP; reset suppresses every grant so the
  // port is quiet during the reset cycle itself.
  assign arb_en   = !reset && (state_q != WAIT);
  assign pick_if  = if_req && (starved || !ls_req);
  assign if_gnt   = arb_en && pick_if;
  assign ls_gnt   = arb_en && ls_req && !pick_if;
  assign read_gnt = if_gnt || (ls_gnt && !ls_we);
  assign stall_o  = arb_en && ((if_req && !if_gnt) || (ls_req && !ls_gnt));

  // Memory port: steer the winner's command straight onto the port.
  always_comb begin
    mem_en    = if_gnt || ls_gnt;
    mem_we    = ls_gnt && ls_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end
  end

  // Transaction sequencer: track the outstanding read, wait out the memory
  // latency, capture the data for its owner and present it for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= REQ_IF;
      lat_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (read_gnt) begin
            state_q <= WAIT;
            owner_q <= if_gnt ? REQ_IF : REQ_LS;
            lat_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_q <= RESP;
            if (owner_q == REQ_IF) begin
              if_rdata_q <= mem_rdata;
            end else begin
              ls_rdata_q <= mem_rdata;
            end
          end else begin
            lat_q <= lat_q + 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A response shown in RESP is dropped if reset hits in that cycle.
  assign if_rvalid = !reset && (state_q == RESP) && (owner_q == REQ_IF);
  assign ls_rvalid = !reset && (state_q == RESP) && (owner_q == REQ_LS);
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

`ifdef ARB_STATS_EN
  logic [31:0] if_acc_q, ls_acc_q;

  // Grant counters; they wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_acc_q <= '0;
      ls_acc_q <= '0;
    end else begin
      if (if_gnt) if_acc_q <= if_acc_q + 32'd1;
      if (ls_gnt) ls_acc_q <= ls_acc_q + 32'd1;
    end
  end

  assign if_acc_cnt = if_acc_q;
  assign ls_acc_cnt = ls_acc_q;
`endif

endmodule
